// File: rtl/div_pkg.sv
//------------------------------------------------------------------------------
// div_pkg : shared widths, iteration count and state encoding for div_unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITER  = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ON   = 2'd1,
      DIV_ZERO = 2'd2,
      DIV_END  = 2'd3
   } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_if.sv
//------------------------------------------------------------------------------
// div_if : request/response bundle between the execute stage and div_unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface div_if;
   import div_pkg::*;

   logic                   start;
   logic                   signed_div;
   logic [DIV_WIDTH-1:0]   a;
   logic [DIV_WIDTH-1:0]   b;
   logic                   annul;
   logic [2*DIV_WIDTH-1:0] result;
   logic                   ready;
   logic                   busy;

   modport master (
      output start, signed_div, a, b, annul,
      input  result, ready, busy
   );

   modport slave (
      input  start, signed_div, a, b, annul,
      output result, ready, busy
   );

endinterface

`default_nettype wire

// File: rtl/div_sign_fix.sv
//------------------------------------------------------------------------------
// div_sign_fix : conditional two's-complement negation (neg ? -val : val)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_sign_fix
   import div_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] val,
   input  logic                 neg,
   output logic [DIV_WIDTH-1:0] res
);

   assign res = neg ? -val : val;

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
//------------------------------------------------------------------------------
// div_unit : 32-bit radix-2 restoring divider producing {remainder, quotient}
// Option   : DIV_ZERO_SHORTCUT_EN -> b==0 finishes in 3 cycles with result 0
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_unit
   import div_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   div_if.slave bus
);

   localparam logic [4:0] LAST_STEP = 5'(DIV_ITER - 1);

   div_state_e             state_q, state_d;
   logic [4:0]             count_q, count_d;
   logic [DIV_WIDTH-1:0]   rem_q, rem_d;
   logic [DIV_WIDTH-1:0]   quo_q, quo_d;
   logic [DIV_WIDTH-1:0]   dvs_q, dvs_d;
   logic                   sgn_q, sgn_d;
   logic                   sa_q, sa_d;
   logic                   sb_q, sb_d;
   logic [2*DIV_WIDTH-1:0] result_q, result_d;

   logic [DIV_WIDTH-1:0]   abs_a, abs_b;
   logic [DIV_WIDTH-1:0]   rem_shift, rem_step, quo_step;
   logic [DIV_WIDTH-1:0]   quo_fixed, rem_fixed;
   logic                   step_ge;

   div_sign_fix u_abs_a (.val(bus.a), .neg(bus.signed_div & bus.a[31]), .res(abs_a));
   div_sign_fix u_abs_b (.val(bus.b), .neg(bus.signed_div & bus.b[31]), .res(abs_b));

   // The partial remainder is always below the divisor, so only 32 bits are
   // stored; the shifted-out bit rem_q[31] acts as bit 32 of the 33-bit value.
   // When it is set the true value exceeds any divisor and the 32-bit
   // difference is still exact.
   assign rem_shift = {rem_q[DIV_WIDTH-2:0], quo_q[DIV_WIDTH-1]};
   assign step_ge   = rem_q[DIV_WIDTH-1] | (rem_shift >= dvs_q);
   assign rem_step  = step_ge ? (rem_shift - dvs_q) : rem_shift;
   assign quo_step  = {quo_q[DIV_WIDTH-2:0], step_ge};

   div_sign_fix u_fix_q (.val(quo_step), .neg(sgn_q & (sa_q ^ sb_q)), .res(quo_fixed));
   div_sign_fix u_fix_r (.val(rem_step), .neg(sgn_q & sa_q),          .res(rem_fixed));

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      sgn_d    = sgn_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      result_d = result_q;

      case (state_q)
         DIV_IDLE: begin
            if (bus.start) begin
               sgn_d   = bus.signed_div;
               sa_d    = bus.a[31];
               sb_d    = bus.b[31];
               rem_d   = '0;
               quo_d   = abs_a;
               dvs_d   = abs_b;
               count_d = '0;
`ifdef DIV_ZERO_SHORTCUT_EN
               state_d = (bus.b == '0) ? DIV_ZERO : DIV_ON;
`else
               state_d = DIV_ON;
`endif
            end
         end
         DIV_ON: begin
            rem_d   = rem_step;
            quo_d   = quo_step;
            count_d = count_q + 5'd1;
            // Result is registered on entry to END so it is valid with ready.
            if (count_q == LAST_STEP) begin
               state_d  = DIV_END;
               result_d = {rem_fixed, quo_fixed};
            end
         end
         DIV_ZERO: begin
            state_d  = DIV_END;
            result_d = '0;
         end
         DIV_END: begin
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase

      if (bus.annul) begin
         state_d  = DIV_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= DIV_IDLE;
         count_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         sgn_q    <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         sgn_q    <= sgn_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         result_q <= result_d;
      end
   end

   assign bus.result = result_q;
   assign bus.ready  = (state_q == DIV_END);
   assign bus.busy   = (state_q != DIV_IDLE);

endmodule

`default_nettype wire
